exec_resp_unit: RTL and testbench

EXEC_RESP_UNIT -- requirements
Module: exec_resp_unit

---
 rtl/pdp8_pkg.sv | 69 ++++++
 rtl/exec_resp_unit_if.sv | 28 ++
 rtl/exec_resp_unit_opcode_check.sv | 31 +++
 rtl/exec_resp_unit.sv | 143 ++++++++++++++
 tb/tb_exec_resp_unit.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 opcode encodings, address constants and the per-class stall latency lookup.
// Pure types/functions, no state.
package pdp8_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o200;

    typedef struct packed {
        logic AND;
        logic TAD;
        logic ISZ;
        logic DCA;
        logic JMS;
        logic JMP;
    } pdp_mem_code_s;

    typedef struct packed {
        pdp_mem_code_s         code;
        logic [ADDR_WIDTH-1:0] mem_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic CLA_CLL;
        logic CLA1;
        logic CLL;
        logic CMA;
        logic CML;
        logic IAC;
        logic RAR;
        logic RTR;
        logic RAL;
        logic RTL;
        logic BSW;
        logic CIA;
        logic NOP;
        logic SMA;
        logic SZA;
        logic SNL;
        logic SPA;
        logic SNA;
        logic SZL;
        logic SKP;
        logic CLA2;
        logic HLT;
    } pdp_op7_opcode_s;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_MEM, CLS_ISZ, CLS_JMS, CLS_JMP,
        CLS_OP7, CLS_SKP, CLS_CSKIP, CLS_HLT, CLS_ERR
    } op_class_e;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DRAIN, ST_HALT} state_e;

    // Stall-high cycle count for a class; HLT and illegal codes always finish in one cycle.
    function automatic logic [7:0] op_latency(input op_class_e cls, input int lat_mem,
                                              input int lat_isz, input int lat_jmp);
        int n;
        case (cls)
            CLS_MEM, CLS_JMS:                     n = lat_mem;
            CLS_ISZ:                              n = lat_isz;
            CLS_JMP, CLS_OP7, CLS_SKP, CLS_CSKIP: n = lat_jmp;
            default:                              n = 1;
        endcase
        if (n < 1)   n = 1;
        if (n > 255) n = 255;
        return 8'(n);
    endfunction

endpackage

// File: rtl/exec_resp_unit_if.sv
// Opcode-in / status-out bundle between the decoder front end and exec_resp_unit.
// No flow control of its own: stall tells the issuer to hold the bus.
interface exec_resp_unit_if;
    import pdp8_pkg::*;

    pdp_mem_opcode_s       pdp_mem_opcode;
    pdp_op7_opcode_s       pdp_op7_opcode;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  skip_cond;
    logic                  resume;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] PC_value;
    logic                  halted;
    logic                  err;
    logic                  retire;
    logic [15:0]           instr_count;

    modport master (
        output pdp_mem_opcode, pdp_op7_opcode, base_addr, skip_cond, resume,
        input  stall, PC_value, halted, err, retire, instr_count
    );

    modport slave (
        input  pdp_mem_opcode, pdp_op7_opcode, base_addr, skip_cond, resume,
        output stall, PC_value, halted, err, retire, instr_count
    );

endinterface

// File: rtl/exec_resp_unit_opcode_check.sv
// Combinational one-hot/legality check and class decode across both opcode buses.
// Zero latency, no backpressure.
module opcode_check
    import pdp8_pkg::*;
(
    input  pdp_mem_code_s   mem_i,
    input  pdp_op7_opcode_s op7_i,
    output logic            valid_o,
    output logic            legal_o,
    output op_class_e       cls_o
);

    assign valid_o = (|mem_i) || (|op7_i);
    // Exactly one bit set across both buses; two live buses count as illegal too.
    assign legal_o = $onehot({mem_i, op7_i});

    always_comb begin
        cls_o = CLS_NONE;
        if (valid_o && !legal_o)                  cls_o = CLS_ERR;
        else if (mem_i.AND || mem_i.TAD || mem_i.DCA) cls_o = CLS_MEM;
        else if (mem_i.ISZ)                       cls_o = CLS_ISZ;
        else if (mem_i.JMS)                       cls_o = CLS_JMS;
        else if (mem_i.JMP)                       cls_o = CLS_JMP;
        else if (op7_i.HLT)                       cls_o = CLS_HLT;
        else if (op7_i.SKP)                       cls_o = CLS_SKP;
        else if (op7_i.SPA || op7_i.SMA || op7_i.SNA ||
                 op7_i.SZA || op7_i.SZL || op7_i.SNL) cls_o = CLS_CSKIP;
        else if (valid_o)                         cls_o = CLS_OP7;
    end

endmodule

// File: rtl/exec_resp_unit.sv
// Accepts one opcode, holds stall for its class latency, then retires it and updates PC.
// Stall is combinational on acceptance; a held opcode is drained, never re-executed.
module exec_resp_unit
    import pdp8_pkg::*;
#(
    parameter int LAT_MEM_SHORT = 2,
    parameter int LAT_ISZ       = 3,
    parameter int LAT_JMP_OP7   = 1
) (
    input logic         clk,
    input logic         reset,
    exec_resp_unit_if.slave bus
);

    state_e                state_q, state_d;
    logic [7:0]            count_q, count_d;
    pdp_mem_opcode_s       mem_q, mem_d, cur_mem;
    pdp_op7_opcode_s       op7_q, op7_d, cur_op7;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_next;
    logic                  halted_q, halted_d, err_q, err_d, retire_q, retire_d;
    logic [15:0]           icount_q, icount_d;
    logic                  chk_valid, chk_legal, stall_c, fin;
    op_class_e             cls;
    logic [7:0]            lat;
    logic                  unused_base;

    // Page base is informational only.
    assign unused_base = ^bus.base_addr;

    // EXEC works from the latched copy; every other state looks at the live bus.
    assign cur_mem = (state_q == ST_EXEC) ? mem_q : bus.pdp_mem_opcode;
    assign cur_op7 = (state_q == ST_EXEC) ? op7_q : bus.pdp_op7_opcode;

    opcode_check u_chk (
        .mem_i   (cur_mem.code),
        .op7_i   (cur_op7),
        .valid_o (chk_valid),
        .legal_o (chk_legal),
        .cls_o   (cls)
    );

    assign lat = op_latency(cls, LAT_MEM_SHORT, LAT_ISZ, LAT_JMP_OP7);

    always_comb begin
        case (cls)
            CLS_JMP:            pc_next = cur_mem.mem_addr;
            CLS_JMS:            pc_next = cur_mem.mem_addr + ADDR_WIDTH'(1);
            CLS_SKP:            pc_next = pc_q + ADDR_WIDTH'(2);
            CLS_ISZ, CLS_CSKIP: pc_next = bus.skip_cond ? pc_q + ADDR_WIDTH'(2)
                                                        : pc_q + ADDR_WIDTH'(1);
            default:            pc_next = pc_q + ADDR_WIDTH'(1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mem_d    = mem_q;
        op7_d    = op7_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        err_d    = err_q;
        retire_d = 1'b0;
        icount_d = icount_q;
        stall_c  = 1'b0;
        fin      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (chk_valid) begin
                    stall_c = 1'b1;
                    mem_d   = bus.pdp_mem_opcode;
                    op7_d   = bus.pdp_op7_opcode;
                    if (lat == 8'd1) begin
                        fin = 1'b1;
                    end else begin
                        count_d = lat - 8'd1;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                stall_c = 1'b1;
                if (count_q <= 8'd1) fin = 1'b1;
                else                 count_d = count_q - 8'd1;
            end
            ST_DRAIN: begin
                if (!chk_valid) state_d = ST_IDLE;
            end
            ST_HALT: begin
                stall_c = 1'b1;
                if (bus.resume) begin
                    halted_d = 1'b0;
                    state_d  = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fin) begin
            pc_d     = pc_next;
            retire_d = 1'b1;
            icount_d = icount_q + 16'd1;
            if (!chk_legal) err_d = 1'b1;
            if (cls == CLS_HLT) begin
                halted_d = 1'b1;
                state_d  = ST_HALT;
            end else begin
                state_d  = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            mem_q    <= '0;
            op7_q    <= '0;
            pc_q     <= START_ADDRESS;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            retire_q <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
            op7_q    <= op7_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            retire_q <= retire_d;
            icount_q <= icount_d;
        end
    end

    assign bus.stall       = stall_c && !reset;
    assign bus.PC_value    = pc_q;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;
    assign bus.retire      = retire_q;
    assign bus.instr_count = icount_q;

endmodule

// File: tb/tb_exec_resp_unit.sv
// Table-driven and hand-sequenced bench for exec_resp_unit; retirements are checked
// against a queue of expected {PC, count, err} pushed when each opcode is issued.
module tb_exec_resp_unit;
    import pdp8_pkg::*;

    typedef struct {
        pdp_mem_opcode_s mem;
        pdp_op7_opcode_s op7;
        logic            skip;
        int              n;
        logic [11:0]     pc;
        logic            err;
    } vec_t;

    typedef struct {
        logic [11:0] pc;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_AND  = 6'b100000;
    localparam logic [5:0] C_TAD  = 6'b010000;
    localparam logic [5:0] C_ISZ  = 6'b001000;
    localparam logic [5:0] C_DCA  = 6'b000100;
    localparam logic [5:0] C_JMS  = 6'b000010;
    localparam logic [5:0] C_JMP  = 6'b000001;
    localparam logic [5:0] C_BAD  = 6'b000011;

    logic clk = 1'b0;
    logic reset = 1'b1;

    exec_resp_unit_if bus();

    exec_resp_unit #(.LAT_MEM_SHORT(2), .LAT_ISZ(3), .LAT_JMP_OP7(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        exp_q[$];
    vec_t        tbl[$];
    logic [15:0] cnt_model = '0;
    logic        err_model = 1'b0;
    pdp_op7_opcode_s o_none, o_iac, o_skp, o_sza, o_sna, o_cla2, o_szl, o_snl, o_hlt, o_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0o, expected %0o (octal)", name, act, exp);
    endtask

    function automatic pdp_mem_opcode_s mk_mem(input logic [5:0] code, input logic [11:0] addr);
        return {code, addr};
    endfunction

    function automatic vec_t mk(input logic [5:0] code, input logic [11:0] addr,
                                input pdp_op7_opcode_s o, input logic sk, input int n,
                                input logic [11:0] pc, input logic e);
        vec_t v;
        v.mem = mk_mem(code, addr);
        v.op7 = o;
        v.skip = sk;
        v.n = n;
        v.pc = pc;
        v.err = e;
        return v;
    endfunction

    task automatic clear_bus();
        bus.pdp_mem_opcode = '0;
        bus.pdp_op7_opcode = '0;
        bus.skip_cond = 1'b0;
        bus.resume = 1'b0;
    endtask

    task automatic push_exp(input logic [11:0] pc, input logic is_err);
        cnt_model++;
        if (is_err) err_model = 1'b1;
        exp_q.push_back('{pc, cnt_model, err_model});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_bus();
        @(negedge clk);
        reset = 1'b0;
        cnt_model = '0;
        err_model = 1'b0;
    endtask

    // Drive an opcode, count stall-high cycles, hold the opcode one cycle into DRAIN.
    task automatic exec_op(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o, input logic sk,
                           input int exp_n, input logic [11:0] exp_pc, input logic is_err,
                           input string tag);
        int n = 0;
        push_exp(exp_pc, is_err);
        @(negedge clk);
        bus.pdp_mem_opcode = m;
        bus.pdp_op7_opcode = o;
        bus.skip_cond = sk;
        #1;
        while (bus.stall === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
        clear_bus();
    endtask

    // Retire scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.retire === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'(bus.retire), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", 32'(bus.PC_value), 32'(e.pc));
                    check("sb_count", 32'(bus.instr_count), 32'(e.cnt));
                    check("sb_err", 32'(bus.err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int bad;
        clear_bus();
        bus.base_addr = 12'o7600;
        o_none = '0;
        o_iac = '0;  o_iac.IAC = 1'b1;
        o_skp = '0;  o_skp.SKP = 1'b1;
        o_sza = '0;  o_sza.SZA = 1'b1;
        o_sna = '0;  o_sna.SNA = 1'b1;
        o_cla2 = '0; o_cla2.CLA2 = 1'b1;
        o_szl = '0;  o_szl.SZL = 1'b1;
        o_snl = '0;  o_snl.SNL = 1'b1;
        o_hlt = '0;  o_hlt.HLT = 1'b1;
        o_bad = '0;  o_bad.IAC = 1'b1; o_bad.CMA = 1'b1;

        tbl.push_back(mk(C_JMP,  12'o1234, o_none, 1'b0, 1, 12'o1234, 1'b0));
        tbl.push_back(mk(C_AND,  12'o0055, o_none, 1'b0, 2, 12'o1235, 1'b0));
        tbl.push_back(mk(C_TAD,  12'o0055, o_none, 1'b0, 2, 12'o1236, 1'b0));
        tbl.push_back(mk(C_DCA,  12'o0055, o_none, 1'b0, 2, 12'o1237, 1'b0));
        tbl.push_back(mk(C_ISZ,  12'o0055, o_none, 1'b1, 3, 12'o1241, 1'b0));
        tbl.push_back(mk(C_ISZ,  12'o0055, o_none, 1'b0, 3, 12'o1242, 1'b0));
        tbl.push_back(mk(C_JMS,  12'o7777, o_none, 1'b0, 2, 12'o0000, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_iac,  1'b0, 1, 12'o0001, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_skp,  1'b0, 1, 12'o0003, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_sza,  1'b1, 1, 12'o0005, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_sna,  1'b0, 1, 12'o0006, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_cla2, 1'b1, 1, 12'o0007, 1'b0));
        tbl.push_back(mk(C_JMP,  12'o7777, o_none, 1'b0, 1, 12'o7777, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_iac,  1'b0, 1, 12'o0000, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_szl,  1'b1, 1, 12'o0002, 1'b0));
        tbl.push_back(mk(C_JMS,  12'o0100, o_none, 1'b0, 2, 12'o0101, 1'b0));
        tbl.push_back(mk(C_BAD,  12'o0000, o_none, 1'b0, 1, 12'o0102, 1'b1));
        tbl.push_back(mk(C_JMP,  12'o0300, o_iac,  1'b0, 1, 12'o0103, 1'b1));
        tbl.push_back(mk(C_TAD,  12'o0055, o_none, 1'b0, 2, 12'o0104, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_snl,  1'b1, 1, 12'o0106, 1'b0));
        tbl.push_back(mk(C_NONE, 12'o0000, o_bad,  1'b0, 1, 12'o0107, 1'b1));

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_pc", 32'(bus.PC_value), 32'o200);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_retire", 32'(bus.retire), 32'd0);
        check("rst_count", 32'(bus.instr_count), 32'd0);

        for (int i = 0; i < tbl.size(); i++)
            exec_op(tbl[i].mem, tbl[i].op7, tbl[i].skip, tbl[i].n, tbl[i].pc, tbl[i].err,
                    $sformatf("vec%0d", i));

        // ISZ from the start address, both skip outcomes.
        do_reset();
        exec_op(mk_mem(C_ISZ, 12'o0010), o_none, 1'b1, 3, 12'o0202, 1'b0, "isz_skip1");
        do_reset();
        exec_op(mk_mem(C_ISZ, 12'o0010), o_none, 1'b0, 3, 12'o0201, 1'b0, "isz_skip0");

        // skip_cond counts only in the final stall cycle; bus changes during EXEC are ignored.
        do_reset();
        push_exp(12'o0202, 1'b0);
        @(negedge clk);
        bus.pdp_mem_opcode = mk_mem(C_ISZ, 12'o0010);
        #1 check("late_c1_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.pdp_mem_opcode = mk_mem(C_JMP, 12'o4000);
        #1 check("late_c2_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.skip_cond = 1'b1;
        #1 check("late_c3_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        #1 check("late_drain_stall", 32'(bus.stall), 32'd0);
        clear_bus();

        // Reset in the second ISZ cycle aborts it.
        do_reset();
        @(negedge clk);
        bus.pdp_mem_opcode = mk_mem(C_ISZ, 12'o0010);
        bus.skip_cond = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        clear_bus();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_pc", 32'(bus.PC_value), 32'o200);
        check("abort_count", 32'(bus.instr_count), 32'd0);
        check("abort_stall", 32'(bus.stall), 32'd0);
        repeat (4) @(negedge clk);

        // HLT: held for 50 cycles, then resumed.
        push_exp(12'o0201, 1'b0);
        @(negedge clk);
        bus.pdp_op7_opcode = o_hlt;
        #1 check("hlt_accept_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        clear_bus();
        #1 check("hlt_halted", 32'(bus.halted), 32'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (bus.stall !== 1'b1 || bus.halted !== 1'b1) bad++;
        end
        check("hlt_hold_50", 32'(bad), 32'd0);
        @(negedge clk);
        bus.resume = 1'b1;
        #1 check("resume_cycle_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.resume = 1'b0;
        #1;
        check("resume_halted", 32'(bus.halted), 32'd0);
        check("resume_stall", 32'(bus.stall), 32'd0);
        check("resume_pc", 32'(bus.PC_value), 32'o201);

        // Resume outside HALT has no effect.
        @(negedge clk);
        bus.resume = 1'b1;
        @(negedge clk);
        bus.resume = 1'b0;
        #1;
        check("idle_resume_halted", 32'(bus.halted), 32'd0);
        check("idle_resume_stall", 32'(bus.stall), 32'd0);
        exec_op(mk_mem(C_NONE, 12'o0000), o_iac, 1'b0, 1, 12'o0202, 1'b0, "after_resume");

        // Reset wins over resume while halted.
        push_exp(12'o0203, 1'b0);
        @(negedge clk);
        bus.pdp_op7_opcode = o_hlt;
        @(negedge clk);
        clear_bus();
        #1 check("hlt2_halted", 32'(bus.halted), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.resume = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.resume = 1'b0;
        cnt_model = '0;
        err_model = 1'b0;
        #1;
        check("rst_resume_halted", 32'(bus.halted), 32'd0);
        check("rst_resume_pc", 32'(bus.PC_value), 32'o200);
        check("rst_resume_stall", 32'(bus.stall), 32'd0);
        check("rst_resume_count", 32'(bus.instr_count), 32'd0);

        // Reset wins over a valid opcode.
        @(negedge clk);
        reset = 1'b1;
        bus.pdp_mem_opcode = mk_mem(C_JMP, 12'o4444);
        @(negedge clk);
        reset = 1'b0;
        clear_bus();
        #1;
        check("rst_op_pc", 32'(bus.PC_value), 32'o200);
        check("rst_op_retire", 32'(bus.retire), 32'd0);
        check("rst_op_count", 32'(bus.instr_count), 32'd0);
        exec_op(mk_mem(C_JMP, 12'o0321), o_none, 1'b0, 1, 12'o0321, 1'b0, "post_rst_jmp");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
